multicycle_ctrl: RTL and testbench

Parametrised multicycle MIPS control FSM, successor to the current five-instruction controller. It sits between the instruction register opcode/funct fields and the multicycle datapath (PC, IR, register file, ALU, unified memory), driving every datapath select and write enable each cycle. Compared with the current controller it adds:
- extended instruction coverage (I-type logic/compare, bne, jal, jr);
- a memory-ready wait handshake;
- a sticky illegal-opcode trap state;
- a parametrised ALU-op width.

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the datapath.
// The controller is the master and drives every datapath select and enable;
// the datapath is the slave and supplies opcode/funct plus memory ready.
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               mem_ready;
  logic [1:0]         PCSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ExtOp;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCWriteCondNe;
  logic [ALUOP_W-1:0] ALUop;
  logic               illegal;
  logic [3:0]         state;

  modport master (
    input  op, funct, mem_ready,
    output PCSrc, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCWrite, PCWriteCond, PCWriteCondNe,
           ALUop, illegal, state
  );

  modport slave (
    output op, funct, mem_ready,
    input  PCSrc, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCWrite, PCWriteCond, PCWriteCondNe,
           ALUop, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM. Moore outputs from the current state, except
// that IF only loads PC/IR on the cycle memory is ready. Unknown opcodes park
// the FSM in a sticky TRAP state until reset.
module multicycle_ctrl #(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_WBM  = 4'd4,
    S_MWR  = 4'd5,
    S_EXR  = 4'd6,
    S_WBR  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_EXI  = 4'd10,
    S_WBI  = 4'd11,
    S_JAL  = 4'd12,
    S_JR   = 4'd13,
    S_TRAP = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   mr;

  logic [1:0] pc_src, alu_b, reg_dst, mem_to_reg;
  logic       alu_a, ext_op, iord, mem_rd, mem_wr, ir_wr, reg_wr;
  logic       pc_wr, pc_wr_c, pc_wr_cne;
  logic [2:0] alu3;
  logic [2:0] i_alu;
  logic       i_ext;
  logic [ALUOP_W-1:0] aluop_full;

  // With the handshake disabled memory is assumed to finish every cycle.
  assign mr = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // I-type ALU flavour; the IR is stable for the whole instruction, so EXI
  // and WBI both decode it directly.
  always_comb begin
    i_alu = ALU_ADD;
    i_ext = 1'b1;
    case (bus.op)
      OP_ANDI: begin i_alu = ALU_AND; i_ext = 1'b0; end
      OP_ORI:  begin i_alu = ALU_OR;  i_ext = 1'b0; end
      OP_SLTI: begin i_alu = ALU_SLT; i_ext = 1'b1; end
      default: begin i_alu = ALU_ADD; i_ext = 1'b1; end
    endcase
  end

  // State register; reset aborts any instruction and restarts at IF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Sticky illegal flag, set on the edge that enters TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 illegal_q <= 1'b0;
    else if (state_d == S_TRAP) illegal_q <= 1'b1;
  end

  // Next-state decode and Moore outputs; reset forces every output to its
  // default so nothing is written while reset is held.
  always_comb begin
    state_d    = state_q;
    pc_src     = 2'b00;
    alu_a      = 1'b0;
    alu_b      = 2'b01;
    ext_op     = 1'b1;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_wr      = 1'b0;
    pc_wr_c    = 1'b0;
    pc_wr_cne  = 1'b0;
    alu3       = ALU_ADD;
    case (state_q)
      S_IF: begin
        state_d = mr ? S_ID : S_IF;
        if (!reset) begin
          mem_rd = 1'b1;
          pc_wr  = mr;
          ir_wr  = mr;
        end
      end
      S_ID: begin
        alu_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:                      state_d = S_MADR;
          OP_R:    state_d = (bus.funct == FN_JR) ? S_JR : S_EXR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
          OP_BEQ, OP_BNE:                    state_d = S_BR;
          OP_J:                              state_d = S_JMP;
          OP_JAL:                            state_d = S_JAL;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MADR: begin
        alu_a   = 1'b1;
        alu_b   = 2'b10;
        state_d = (bus.op == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        state_d = mr ? S_WBM : S_MRD;
      end
      S_WBM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_IF;
      end
      S_MWR: begin
        mem_wr  = 1'b1;
        iord    = 1'b1;
        state_d = mr ? S_IF : S_MWR;
      end
      S_EXR: begin
        alu_a   = 1'b1;
        alu_b   = 2'b00;
        alu3    = ALU_FN;
        state_d = S_WBR;
      end
      S_WBR: begin
        reg_wr  = 1'b1;
        reg_dst = 2'b01;
        state_d = S_IF;
      end
      S_BR: begin
        alu_a     = 1'b1;
        alu_b     = 2'b00;
        alu3      = ALU_SUB;
        pc_src    = 2'b01;
        pc_wr_c   = (bus.op == OP_BEQ);
        pc_wr_cne = (bus.op == OP_BNE);
        state_d   = S_IF;
      end
      S_JMP: begin
        pc_src  = 2'b10;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_EXI: begin
        alu_a   = 1'b1;
        alu_b   = 2'b10;
        alu3    = i_alu;
        ext_op  = i_ext;
        state_d = S_WBI;
      end
      S_WBI: begin
        reg_wr  = 1'b1;
        alu3    = i_alu;
        ext_op  = i_ext;
        state_d = S_IF;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_wr      = 1'b1;
        reg_wr     = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        state_d    = S_IF;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  // ALUop upper bits above the 3-bit code are always zero.
  always_comb begin
    aluop_full      = '0;
    aluop_full[2:0] = alu3;
  end

  assign bus.PCSrc         = pc_src;
  assign bus.ALUSrcA       = alu_a;
  assign bus.ALUSrcB       = alu_b;
  assign bus.ExtOp         = ext_op;
  assign bus.IorD          = iord;
  assign bus.MemRead       = mem_rd;
  assign bus.MemWrite      = mem_wr;
  assign bus.IRWrite       = ir_wr;
  assign bus.RegWrite      = reg_wr;
  assign bus.RegDst        = reg_dst;
  assign bus.MemtoReg      = mem_to_reg;
  assign bus.PCWrite       = pc_wr;
  assign bus.PCWriteCond   = pc_wr_c;
  assign bus.PCWriteCondNe = pc_wr_cne;
  assign bus.ALUop         = aluop_full;
  assign bus.illegal       = illegal_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: one table entry per clock cycle
// giving inputs and the expected state and control word for that cycle.
module tb_multicycle_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUOP_W(AW)) bus ();
  multicycle_ctrl #(.ALUOP_W(AW), .MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]    PCSrc;
    logic          ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic          ExtOp;
    logic          IorD;
    logic          MemRead;
    logic          MemWrite;
    logic          IRWrite;
    logic          RegWrite;
    logic [1:0]    RegDst;
    logic [1:0]    MemtoReg;
    logic          PCWrite;
    logic          PCWriteCond;
    logic          PCWriteCondNe;
    logic [AW-1:0] ALUop;
    logic          illegal;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mr;
    logic [3:0] st;
    ctl_t       c;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    c.ALUSrcB = 2'b01;
    c.ExtOp   = 1'b1;
    return c;
  endfunction

  function automatic ctl_t actual();
    ctl_t c;
    c = {bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.IorD, bus.MemRead,
         bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
         bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.ALUop, bus.illegal};
    return c;
  endfunction

  task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                     input logic mr, input logic [3:0] st, input ctl_t c);
    vec_t v;
    v.name = n; v.op = op; v.funct = fn; v.mr = mr; v.st = st; v.c = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [3:0] st, input ctl_t c);
    tests++;
    if (bus.state !== st) begin
      fails++;
      $display("FAIL %s state: got %0d want %0d", n, bus.state, st);
    end
    tests++;
    if (actual() !== c) begin
      fails++;
      $display("FAIL %s ctl: got %h want %h", n, actual(), c);
    end
  endtask

  // Common per-state expectations, written from the control table.
  function automatic ctl_t c_if(input logic mr);
    ctl_t c; c = dflt(); c.MemRead = 1; c.PCWrite = mr; c.IRWrite = mr; return c;
  endfunction
  function automatic ctl_t c_id();
    ctl_t c; c = dflt(); c.ALUSrcB = 2'b11; return c;
  endfunction
  function automatic ctl_t c_madr();
    ctl_t c; c = dflt(); c.ALUSrcA = 1; c.ALUSrcB = 2'b10; return c;
  endfunction
  function automatic ctl_t c_mrd();
    ctl_t c; c = dflt(); c.MemRead = 1; c.IorD = 1; return c;
  endfunction

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FJR = 6'b001000;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t c;
    // R-type add
    add("add IF", R, FADD, 1, 0, c_if(1));
    add("add ID", R, FADD, 1, 1, c_id());
    c = dflt(); c.ALUSrcA = 1; c.ALUSrcB = 2'b00; c.ALUop = 4'b0010;
    add("add EXR", R, FADD, 1, 6, c);
    c = dflt(); c.RegWrite = 1; c.RegDst = 2'b01;
    add("add WBR", R, FADD, 1, 7, c);
    // lw
    add("lw IF", LW, 0, 1, 0, c_if(1));
    add("lw ID", LW, 0, 1, 1, c_id());
    add("lw MADR", LW, 0, 1, 2, c_madr());
    add("lw MRD", LW, 0, 1, 3, c_mrd());
    c = dflt(); c.RegWrite = 1; c.MemtoReg = 2'b01;
    add("lw WBM", LW, 0, 1, 4, c);
    // sw
    add("sw IF", SW, 0, 1, 0, c_if(1));
    add("sw ID", SW, 0, 1, 1, c_id());
    add("sw MADR", SW, 0, 1, 2, c_madr());
    c = dflt(); c.MemWrite = 1; c.IorD = 1;
    add("sw MWR", SW, 0, 1, 5, c);
    // ori
    add("ori IF", ORI, 0, 1, 0, c_if(1));
    add("ori ID", ORI, 0, 1, 1, c_id());
    c = dflt(); c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ExtOp = 0; c.ALUop = 4'b0100;
    add("ori EXI", ORI, 0, 1, 10, c);
    c = dflt(); c.RegWrite = 1; c.ExtOp = 0; c.ALUop = 4'b0100;
    add("ori WBI", ORI, 0, 1, 11, c);
    // slti
    add("slti IF", SLTI, 0, 1, 0, c_if(1));
    add("slti ID", SLTI, 0, 1, 1, c_id());
    c = dflt(); c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUop = 4'b0101;
    add("slti EXI", SLTI, 0, 1, 10, c);
    c = dflt(); c.RegWrite = 1; c.ALUop = 4'b0101;
    add("slti WBI", SLTI, 0, 1, 11, c);
    // beq / bne
    add("beq IF", BEQ, 0, 1, 0, c_if(1));
    add("beq ID", BEQ, 0, 1, 1, c_id());
    c = dflt(); c.ALUSrcA = 1; c.ALUSrcB = 2'b00; c.ALUop = 4'b0001;
    c.PCSrc = 2'b01; c.PCWriteCond = 1;
    add("beq BR", BEQ, 0, 1, 8, c);
    add("bne IF", BNE, 0, 1, 0, c_if(1));
    add("bne ID", BNE, 0, 1, 1, c_id());
    c.PCWriteCond = 0; c.PCWriteCondNe = 1;
    add("bne BR", BNE, 0, 1, 8, c);
    // jal / jr
    add("jal IF", JAL, 0, 1, 0, c_if(1));
    add("jal ID", JAL, 0, 1, 1, c_id());
    c = dflt(); c.PCSrc = 2'b10; c.PCWrite = 1; c.RegWrite = 1;
    c.RegDst = 2'b10; c.MemtoReg = 2'b10;
    add("jal JAL", JAL, 0, 1, 12, c);
    add("jr IF", R, FJR, 1, 0, c_if(1));
    add("jr ID", R, FJR, 1, 1, c_id());
    c = dflt(); c.PCSrc = 2'b11; c.PCWrite = 1;
    add("jr JR", R, FJR, 1, 13, c);
    // lw with three wait cycles in IF and in MRD: 11 cycles total
    for (int i = 0; i < 3; i++) add("lwW IFwait", LW, 0, 0, 0, c_if(0));
    add("lwW IF", LW, 0, 1, 0, c_if(1));
    add("lwW ID", LW, 0, 1, 1, c_id());
    add("lwW MADR", LW, 0, 1, 2, c_madr());
    for (int i = 0; i < 3; i++) add("lwW MRDwait", LW, 0, 0, 3, c_mrd());
    add("lwW MRD", LW, 0, 1, 3, c_mrd());
    c = dflt(); c.RegWrite = 1; c.MemtoReg = 2'b01;
    add("lwW WBM", LW, 0, 1, 4, c);
    // illegal opcode traps and stays
    add("bad IF", BAD, 0, 1, 0, c_if(1));
    add("bad ID", BAD, 0, 1, 1, c_id());
    c = dflt(); c.illegal = 1;
    for (int i = 0; i < 3; i++) add("bad TRAP", BAD, 0, 1, 15, c);

    // Reset held: IF state but every output at default, MemRead included.
    reset = 1'b1; bus.op = R; bus.funct = FADD; bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    check("reset held", 4'd0, dflt());
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.op = vecs[i].op; bus.funct = vecs[i].funct; bus.mem_ready = vecs[i].mr;
      #1;
      check(vecs[i].name, vecs[i].st, vecs[i].c);
      @(negedge clk);
    end

    // Reset clears the sticky flag out of TRAP.
    reset = 1'b1; #1;
    check("trap reset", 4'd0, dflt());
    @(negedge clk); reset = 1'b0;

    // sw stalled in MWR, then reset mid-cycle aborts the write immediately.
    bus.op = SW; bus.funct = 0; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0; #1;
    c = dflt(); c.MemWrite = 1; c.IorD = 1;
    check("sw MWRwait", 4'd5, c);
    @(negedge clk); #1;
    check("sw MWRhold", 4'd5, c);
    #1 reset = 1'b1; #1;
    check("MWR reset", 4'd0, dflt());
    @(negedge clk); #1;
    check("MWR reset held", 4'd0, dflt());
    reset = 1'b0; #1;
    check("post-reset IF wait", 4'd0, c_if(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
